// File: rtl/snn_tdm_layer_if.sv
// Control, spike and weight-write bundle for one snn_tdm_layer.
// The layer is the slave; whatever sequences timesteps and loads weights is the master.
interface snn_tdm_layer_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int WW    = 8,
    parameter int AW    = 4
);
    logic                 start;
    logic [N_IN-1:0]      in_spikes;
    logic                 w_we;
    logic [AW-1:0]        w_addr;
    logic signed [WW-1:0] w_data;
    logic                 busy;
    logic                 done;
    logic [N_OUT-1:0]     out_spikes;

    modport master (
        output start, in_spikes, w_we, w_addr, w_data,
        input  busy, done, out_spikes
    );

    modport slave (
        input  start, in_spikes, w_we, w_addr, w_data,
        output busy, done, out_spikes
    );
endinterface

// File: rtl/snn_tdm_layer.sv
// Time-multiplexed fully-connected leaky integrate-and-fire layer: one adder
// sweeps every synapse (neuron-major, input-minor) once per start strobe.
module snn_tdm_layer #(
    parameter int                   N_IN       = 4,
    parameter int                   N_OUT      = 4,
    parameter int                   WW         = 8,
    parameter int                   VW         = 16,
    parameter logic signed [VW-1:0] THRESH     = 100,
    parameter int                   LEAK_SHIFT = 3,
    localparam int                  N_SYN      = N_IN * N_OUT,
    localparam int                  AW         = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
    input  logic          clk,
    input  logic          rst,
    snn_tdm_layer_if.slave s_bus
);
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int EW = VW + $clog2(N_IN) + WW;
    localparam logic signed [EW-1:0] V_MAX = EW'((64'sd1 <<< (VW - 1)) - 64'sd1);
    localparam logic signed [EW-1:0] V_MIN = ~V_MAX;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FIRE} state_t;

    state_t               r_state;
    logic [N_IN-1:0]      r_spk_q;
    logic [IW-1:0]        r_i;
    logic [JW-1:0]        r_j;
    logic signed [EW-1:0] r_acc;
    logic signed [VW-1:0] r_v [N_OUT];
    logic signed [WW-1:0] r_w [N_SYN];
    logic [N_OUT-1:0]     r_spk_next;
    logic [N_OUT-1:0]     r_out_spikes;
    logic                 r_busy;
    logic                 r_done;

    logic [AW-1:0]        w_rd_addr;
    logic signed [EW-1:0] w_term;
    logic signed [EW-1:0] w_acc_final;
    logic signed [VW-1:0] w_v_cur;
    logic signed [EW-1:0] w_v_ext;
    logic signed [EW-1:0] w_leak;
    logic signed [EW-1:0] w_v_new;
    logic signed [VW-1:0] w_v_sat;
    logic                 w_fire;
    logic [N_OUT-1:0]     w_spk_merged;

    // NOTE: the weight store is cleared by rst like any other state, so it must stay a
    // register array rather than a RAM macro; a read colliding with a write sees the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_SYN; k++) r_w[k] <= '0;
        end else if (s_bus.w_we && (32'(s_bus.w_addr) < N_SYN)) begin
            r_w[s_bus.w_addr] <= s_bus.w_data;
        end
    end

    always_comb begin
        w_rd_addr   = AW'(32'(r_i) * N_OUT + 32'(r_j));
        w_term      = '0;
        if (r_spk_q[r_i]) w_term = EW'(r_w[w_rd_addr]);
        w_acc_final = r_acc + w_term;

        w_v_cur = r_v[r_j];
        w_v_ext = EW'(w_v_cur);
        w_leak  = '0;
        if (LEAK_SHIFT > 0) w_leak = w_v_ext >>> LEAK_SHIFT;
        w_v_new = w_v_ext - w_leak + w_acc_final;

        // Wide intermediate plus clamp: the membrane pins at the rails instead of wrapping.
        if (w_v_new > V_MAX) begin
            w_v_sat = V_MAX[VW-1:0];
        end else if (w_v_new < V_MIN) begin
            w_v_sat = V_MIN[VW-1:0];
        end else begin
            w_v_sat = w_v_new[VW-1:0];
        end

        w_fire            = (w_v_sat >= THRESH);
        w_spk_merged      = r_spk_next;
        w_spk_merged[r_j] = w_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_spk_q      <= '0;
            r_i          <= '0;
            r_j          <= '0;
            r_acc        <= '0;
            r_spk_next   <= '0;
            r_out_spikes <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            for (int k = 0; k < N_OUT; k++) r_v[k] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (s_bus.start) begin
                        r_spk_q <= s_bus.in_spikes;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (32'(r_i) == N_IN - 1) begin
                        r_v[r_j]   <= w_fire ? '0 : w_v_sat;
                        r_spk_next <= w_spk_merged;
                        r_acc      <= '0;
                        r_i        <= '0;
                        if (32'(r_j) == N_OUT - 1) begin
                            r_j          <= '0;
                            r_out_spikes <= w_spk_merged;
                            r_done       <= 1'b1;
                            r_state      <= S_FIRE;
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end else begin
                        r_acc <= w_acc_final;
                        r_i   <= r_i + 1'b1;
                    end
                end
                S_FIRE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_bus.busy       = r_busy;
    assign s_bus.done       = r_done;
    assign s_bus.out_spikes = r_out_spikes;
endmodule

// File: tb/tb_snn_tdm_layer.sv
// Bench for snn_tdm_layer: three instances (default, 12-bit no-leak, 3-input) share one
// stimulus stream and are compared against a timestep-level arithmetic model.
module tb_snn_tdm_layer;
    localparam int NDUT  = 3;
    localparam int N_OUT = 4;
    localparam int THR   = 100;
    localparam int NI  [NDUT] = '{4, 4, 3};
    localparam int VWD [NDUT] = '{16, 12, 16};
    localparam int LSD [NDUT] = '{3, 0, 3};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] in_spikes = '0;
    logic       w_we = 1'b0;
    logic [3:0] w_addr = '0;
    logic [7:0] w_data = '0;

    int         n_checks = 0;
    int         n_errors = 0;
    int         mw [NDUT][16];
    int         mv [NDUT][N_OUT];
    logic [3:0] last_out [NDUT];
    logic [3:0] held_exp;

    typedef struct {
        logic [3:0] spikes;
        logic [3:0] exp_a;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    snn_tdm_layer_if #(.N_IN(4), .N_OUT(4), .WW(8), .AW(4)) bus_a ();
    snn_tdm_layer_if #(.N_IN(4), .N_OUT(4), .WW(8), .AW(4)) bus_b ();
    snn_tdm_layer_if #(.N_IN(3), .N_OUT(4), .WW(8), .AW(4)) bus_c ();

    assign bus_a.start = start;  assign bus_b.start = start;  assign bus_c.start = start;
    assign bus_a.w_we  = w_we;   assign bus_b.w_we  = w_we;   assign bus_c.w_we  = w_we;
    assign bus_a.w_addr = w_addr; assign bus_b.w_addr = w_addr; assign bus_c.w_addr = w_addr;
    assign bus_a.w_data = w_data; assign bus_b.w_data = w_data; assign bus_c.w_data = w_data;
    assign bus_a.in_spikes = in_spikes;
    assign bus_b.in_spikes = in_spikes;
    assign bus_c.in_spikes = in_spikes[2:0];

    snn_tdm_layer dut_a (.clk(clk), .rst(rst), .s_bus(bus_a));
    snn_tdm_layer #(.VW(12), .LEAK_SHIFT(0)) dut_b (.clk(clk), .rst(rst), .s_bus(bus_b));
    snn_tdm_layer #(.N_IN(3)) dut_c (.clk(clk), .rst(rst), .s_bus(bus_c));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] dut_out(input int d);
        case (d)
            0:       return bus_a.out_spikes;
            1:       return bus_b.out_spikes;
            default: return {1'b0, bus_c.out_spikes[2:0]} | {bus_c.out_spikes[3], 3'b000};
        endcase
    endfunction

    function automatic logic dut_done(input int d);
        case (d)
            0:       return bus_a.done;
            1:       return bus_b.done;
            default: return bus_c.done;
        endcase
    endfunction

    function automatic logic dut_busy(input int d);
        case (d)
            0:       return bus_a.busy;
            1:       return bus_b.busy;
            default: return bus_c.busy;
        endcase
    endfunction

    // Reference: one whole timestep at once, from the neuron equations.
    function automatic logic [3:0] model_step(input int d, input logic [3:0] spk);
        logic [3:0] fired;
        int vmax, vmin, acc, v;
        fired = '0;
        vmax  = (1 <<< (VWD[d] - 1)) - 1;
        vmin  = -vmax - 1;
        for (int j = 0; j < N_OUT; j++) begin
            acc = 0;
            for (int i = 0; i < NI[d]; i++) if (spk[i]) acc += mw[d][i * N_OUT + j];
            v = mv[d][j];
            if (LSD[d] > 0) v = v - (v >>> LSD[d]);
            v = v + acc;
            if (v > vmax) v = vmax;
            else if (v < vmin) v = vmin;
            if (v >= THR) begin
                fired[j] = 1'b1;
                v = 0;
            end
            mv[d][j] = v;
        end
        return fired;
    endfunction

    function automatic void model_write(input int d, input int a, input int val);
        if (a < NI[d] * N_OUT) mw[d][a] = val;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < NDUT; d++) begin
            for (int a = 0; a < 16; a++) mw[d][a] = 0;
            for (int j = 0; j < N_OUT; j++) mv[d][j] = 0;
        end
    endfunction

    // Cycle (1-based, within ACCUM) in which weight a is read: neuron-major, input-minor.
    function automatic int read_cycle(input int d, input int a);
        return (a % N_OUT) * NI[d] + a / N_OUT + 1;
    endfunction

    task automatic wr(input int a, input int val);
        @(negedge clk);
        w_we   = 1'b1;
        w_addr = a[3:0];
        w_data = val[7:0];
        for (int d = 0; d < NDUT; d++) model_write(d, a, val);
        @(negedge clk);
        w_we = 1'b0;
    endtask

    // One timestep; optional start glitch, mid-step write and mid-step reset at given cycles.
    task automatic run_step(input logic [3:0] spk, input int glitch_c, input int wr_c,
                            input int wr_a, input int wr_d, input int rst_c);
        logic [3:0] exp_out [NDUT];
        int done_c [NDUT];
        int done_n [NDUT];
        int busy_bad;
        bit pre;
        busy_bad = 0;
        for (int d = 0; d < NDUT; d++) begin
            done_c[d]  = -1;
            done_n[d]  = 0;
            exp_out[d] = '0;
            if (rst_c == 0) begin
                pre = (wr_c > 0) && (read_cycle(d, wr_a) > wr_c);
                if (pre) model_write(d, wr_a, wr_d);
                exp_out[d] = model_step(d, spk);
                if (wr_c > 0 && !pre) model_write(d, wr_a, wr_d);
            end
        end
        @(negedge clk);
        check("idle_before_start", 32'(bus_a.busy), 32'd0);
        check("out_held", 32'(bus_a.out_spikes), 32'(held_exp));
        start     = 1'b1;
        in_spikes = spk;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            start = 1'b0;
            w_we  = 1'b0;
            for (int d = 0; d < NDUT; d++) begin
                if (dut_done(d)) begin
                    done_n[d]++;
                    if (done_c[d] < 0) done_c[d] = c;
                    last_out[d] = dut_out(d);
                end
            end
            if (bus_a.busy !== 1'b1) busy_bad++;
            if (c == rst_c) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                for (int d = 0; d < NDUT; d++) begin
                    check($sformatf("rst_busy_dut%0d", d), 32'(dut_busy(d)), 32'd0);
                    check($sformatf("rst_done_dut%0d", d), 32'(dut_done(d)), 32'd0);
                    check($sformatf("rst_out_dut%0d", d), 32'(dut_out(d)), 32'd0);
                end
                check("no_done_before_rst", 32'(done_n[0]), 32'd0);
                model_reset();
                held_exp = '0;
                return;
            end
            if (c == glitch_c) start = 1'b1;
            if (c == wr_c) begin
                w_we   = 1'b1;
                w_addr = wr_a[3:0];
                w_data = wr_d[7:0];
            end
        end
        check("busy_cycles_1_17", 32'(busy_bad), 32'd0);
        check("done_cycle_a", 32'(done_c[0]), 32'd17);
        check("done_count_a", 32'(done_n[0]), 32'd1);
        check("done_count_b", 32'(done_n[1]), 32'd1);
        check("done_cycle_c", 32'(done_c[2]), 32'd13);
        for (int d = 0; d < NDUT; d++)
            check($sformatf("out_spikes_dut%0d", d), 32'(last_out[d]), 32'(exp_out[d]));
        held_exp = exp_out[0];
    endtask

    initial begin
        int nw, wc, gc;
        vecs[0] = '{4'b1111, 4'b0010};
        vecs[1] = '{4'b1111, 4'b0011};
        vecs[2] = '{4'b1111, 4'b0010};
        vecs[3] = '{4'b0011, 4'b0001};
        vecs[4] = '{4'b0000, 4'b0000};
        vecs[5] = '{4'b1100, 4'b0000};
        vecs[6] = '{4'b1111, 4'b0011};
        model_reset();
        held_exp = '0;
        for (int d = 0; d < NDUT; d++) last_out[d] = '1;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("reset_busy_dut%0d", d), 32'(dut_busy(d)), 32'd0);
            check($sformatf("reset_done_dut%0d", d), 32'(dut_done(d)), 32'd0);
            check($sformatf("reset_out_dut%0d", d), 32'(dut_out(d)), 32'd0);
        end

        // Zero weights after reset: a full step must produce no spikes.
        run_step(4'b1111, 0, 0, 0, 0, 0);
        check("zero_weights_out", 32'(last_out[0]), 32'd0);

        // Integration, leak and threshold equality.
        for (int i = 0; i < 4; i++) begin
            wr(i * 4 + 0, 20);
            wr(i * 4 + 1, 25);
        end
        for (int v = 0; v < 7; v++) begin
            run_step(vecs[v].spikes, 0, 0, 0, 0, 0);
            check($sformatf("vec%0d_out", v), 32'(last_out[0]), 32'(vecs[v].exp_a));
        end

        // Saturation on the 12-bit no-leak instance: clamp at -2048, then climb out.
        for (int i = 0; i < 4; i++) begin
            wr(i * 4 + 0, -128);
            wr(i * 4 + 1, 0);
        end
        for (int s = 0; s < 5; s++) begin
            run_step(4'b1111, 0, 0, 0, 0, 0);
            check($sformatf("sat_down_step%0d", s), 32'(last_out[1][0]), 32'd0);
        end
        for (int i = 0; i < 4; i++) wr(i * 4 + 0, 127);
        for (int s = 0; s < 5; s++) begin
            run_step(4'b1111, 0, 0, 0, 0, 0);
            check($sformatf("sat_up_step%0d", s), 32'(last_out[1][0]), 32'(s == 4));
        end

        // Protocol: start while busy, out-of-range writes, writes racing the sweep.
        run_step(4'b0000, 5, 0, 0, 0, 0);
        wr(12, 100);
        wr(13, 100);
        run_step(4'b1111, 0, 0, 0, 0, 0);
        run_step(4'b0001, 0, 2, 3, 100, 0);
        check("midstep_write_used", 32'(last_out[0][3]), 32'd1);
        run_step(4'b0001, 0, 1, 0, -100, 0);
        run_step(4'b0001, 0, 0, 0, 0, 0);

        // Reset mid-step, then a quiet step on cleared weights.
        run_step(4'b1111, 0, 0, 0, 0, 8);
        run_step(4'b1111, 0, 0, 0, 0, 0);
        for (int d = 0; d < NDUT; d++)
            check($sformatf("post_rst_quiet_dut%0d", d), 32'(last_out[d]), 32'd0);

        for (int k = 0; k < 40; k++) begin
            nw = $urandom_range(0, 3);
            for (int m = 0; m < nw; m++)
                wr(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)) - 128);
            wc = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 15)) : 0;
            gc = ($urandom_range(0, 9) < 2) ? int'($urandom_range(2, 12)) : 0;
            run_step(4'($urandom), gc, wc, int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 255)) - 128, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
